// File: rtl/qspi_cache_pkg.sv
// Shared definitions for the QSPI read cache.
// Holds the controller state type, the bus widths and helpers that derive
// the offset / index / tag field widths from the cache geometry.
package qspi_cache_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    ISSUE,
    FILL,
    RESPOND
  } cache_state_t;

  // Word-offset field width (zero when a line holds a single word).
  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  // Word-select signal width; never zero so it can size a real vector.
  function automatic int sel_w(input int line_words);
    return (off_w(line_words) > 0) ? off_w(line_words) : 1;
  endfunction

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines, input int line_words);
    return ADDR_W - 2 - off_w(line_words) - idx_w(lines);
  endfunction

endpackage

// File: rtl/qspi_cache_ctrl_mem.sv
// cache_mem: tag, valid and data storage for the direct-mapped cache.
// Ports:
//   clk, rst           clock, synchronous active-high reset (valid bits only)
//   clr_all            clears every valid bit on the next edge
//   wr_idx             line index shared by all write-side controls
//   wr_en, wr_sel, wr_data   write one data word of line wr_idx
//   tag_we, wr_tag     write the tag of line wr_idx
//   set_valid          mark line wr_idx valid (clr_all wins)
//   rd_idx, rd_sel     asynchronous read address
//   rd_data, rd_tag, rd_valid   asynchronous read results
module cache_mem
  import qspi_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = 4,
  parameter int SEL_W      = 2,
  parameter int TAG_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_all,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              tag_we,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              set_valid,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [DATA_W-1:0] rd_data,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid
);

  logic [DATA_W-1:0] data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [LINES-1:0]  valid_q;

  // Data and tags are deliberately not reset; valid_q gates their use.
  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx][wr_sel] <= wr_data;
    if (tag_we) tag_q[wr_idx] <= wr_tag;
  end

  always_ff @(posedge clk) begin
    if (rst || clr_all) valid_q <= '0;
    else if (set_valid) valid_q[wr_idx] <= 1'b1;
  end

  assign rd_data  = data_q[rd_idx][rd_sel];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];

endmodule

// File: rtl/qspi_cache_ctrl.sv
// qspi_cache_ctrl: direct-mapped read cache in front of a QSPI flash reader.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid, req_addr, req_ready   CPU read request (byte address, [1:0] ignored)
//   rsp_valid, rsp_data          one-cycle response strobe, data holds otherwise
//   inval                        invalidate all lines
//   flash_addr, flash_read_en    line-aligned burst address and start pulse
//   flash_dout, flash_dval       returned burst words
//   flash_rready                 QSPI side idle and able to start a burst
//
// state   | meaning
// IDLE    | ready for a CPU request
// LOOKUP  | compare tag of the latched address; hit answers here
// ISSUE   | wait for flash_rready, then start the line burst
// FILL    | write returned words into the line
// RESPOND | return the requested word of the freshly filled line
module qspi_cache_ctrl
  import qspi_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              inval,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_read_en,
  input  logic [DATA_W-1:0] flash_dout,
  input  logic              flash_dval,
  input  logic              flash_rready
);

  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int SEL_W = sel_w(LINE_WORDS);
  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(LINES, LINE_WORDS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << (2 + OFF_W)) - 1);
  localparam logic [ADDR_W-1:0] SEL_MASK  = ADDR_W'(LINE_WORDS - 1);

  cache_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [SEL_W-1:0]  fill_cnt;
  logic              pend_inval;
  logic [DATA_W-1:0] rsp_hold;

  logic [SEL_W-1:0]  cur_sel;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] rd_data;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid;
  logic              hit;
  logic              fill_last;
  logic              mem_we;
  logic              line_done;
  logic              set_valid;

  assign cur_sel   = SEL_W'((addr_q >> 2) & SEL_MASK);
  assign cur_idx   = IDX_W'(addr_q >> (2 + OFF_W));
  assign cur_tag   = TAG_W'(addr_q >> (2 + OFF_W + IDX_W));
  assign hit       = rd_valid && (rd_tag == cur_tag);
  assign fill_last = (fill_cnt == SEL_W'(LINE_WORDS - 1));

  // An inval arriving on the very cycle the line completes must also
  // keep the line invalid, not only an inval seen earlier in the miss.
  assign set_valid = line_done && !inval && !pend_inval;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    rsp_valid     = 1'b0;
    flash_read_en = 1'b0;
    mem_we        = 1'b0;
    line_done     = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          rsp_valid = 1'b1;
          state_d   = IDLE;
        end else begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (flash_rready) begin
          flash_read_en = 1'b1;
          state_d       = FILL;
        end
      end
      FILL: begin
        if (flash_dval) begin
          mem_we = 1'b1;
          if (fill_last) begin
            line_done = 1'b1;
            state_d   = RESPOND;
          end
        end
      end
      RESPOND: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q     <= '0;
      fill_cnt   <= '0;
      pend_inval <= 1'b0;
      rsp_hold   <= '0;
      flash_addr <= '0;
    end else begin
      if (req_valid && req_ready) addr_q <= req_addr;
      if (state_q == LOOKUP && !hit) flash_addr <= addr_q & LINE_MASK;
      if (mem_we) fill_cnt <= line_done ? '0 : fill_cnt + 1'b1;
      if (state_d == IDLE) pend_inval <= 1'b0;
      else if (inval && (state_q == LOOKUP || state_q == ISSUE || state_q == FILL))
        pend_inval <= 1'b1;
      if (rsp_valid) rsp_hold <= rd_data;
    end
  end

  // The response word is read straight from the array so a hit answers in
  // the LOOKUP cycle; rsp_hold keeps the last word visible between strobes.
  assign rsp_data = rsp_valid ? rd_data : rsp_hold;

  cache_mem #(
    .LINES     (LINES),
    .LINE_WORDS(LINE_WORDS),
    .IDX_W     (IDX_W),
    .SEL_W     (SEL_W),
    .TAG_W     (TAG_W)
  ) u_mem (
    .clk      (clk),
    .rst      (rst),
    .clr_all  (inval),
    .wr_idx   (cur_idx),
    .wr_en    (mem_we),
    .wr_sel   (fill_cnt),
    .wr_data  (flash_dout),
    .tag_we   (line_done),
    .wr_tag   (cur_tag),
    .set_valid(set_valid),
    .rd_idx   (cur_idx),
    .rd_sel   (cur_sel),
    .rd_data  (rd_data),
    .rd_tag   (rd_tag),
    .rd_valid (rd_valid)
  );

endmodule

// File: tb/tb_qspi_cache_ctrl.sv
module tb_qspi_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [23:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        inval = 1'b0;
  logic [23:0] flash_addr;
  logic        flash_read_en;
  logic [31:0] flash_dout = '0;
  logic        flash_dval = 1'b0;
  logic        flash_rready = 1'b1;

  qspi_cache_ctrl #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .inval        (inval),
    .flash_addr   (flash_addr),
    .flash_read_en(flash_read_en),
    .flash_dout   (flash_dout),
    .flash_dval   (flash_dval),
    .flash_rready (flash_rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int rd_en_cnt = 0;
  bit chk_en = 0;
  logic [31:0] exp_rsp[$];
  logic [23:0] exp_fetch[$];
  logic [31:0] last_rsp = '0;
  logic [23:0] last_faddr = '0;

  // Cache model: 16 lines of 16 bytes; index = (addr/16)%16, tag = addr/256.
  bit          m_valid[16];
  logic [15:0] m_tag[16];

  // Flash content: every word carries its own word address.
  function automatic logic [31:0] fw(input logic [23:0] a);
    return 32'hD000_0000 | 32'(a & 24'hFFFFFC);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    foreach (m_valid[i]) m_valid[i] = 0;
  endtask

  task automatic abort_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "bench stopped on timeout");
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (flash_read_en) begin
        rd_en_cnt++;
        last_faddr = flash_addr;
        if (exp_fetch.size() == 0) check("unexpected_read_en", 32'(flash_read_en), 0);
        else check("fetch_addr", 32'(flash_addr), 32'(exp_fetch.pop_front()));
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 0);
        else check("rsp_data", rsp_data, exp_rsp.pop_front());
        last_rsp = rsp_data;
      end else begin
        check("rsp_hold", rsp_data, last_rsp);
      end
    end
  end

  // inval_at: >0 pulse inval after that dval; <0 pulse inval in the LOOKUP cycle.
  // rst_at: >0 reset after that dval.
  task automatic do_req(input logic [23:0] a, input int stall, input int inval_at, input int rst_at);
    int          idx;
    logic [15:0] tg;
    logic [23:0] line;
    bit          hit;
    bit          pend;
    bit          seen;
    int          n0;
    idx  = int'(a >> 4) % 16;
    tg   = 16'(a / 256);
    line = a & 24'hFFFFF0;
    hit  = m_valid[idx] && (m_tag[idx] == tg);
    pend = 0;
    n0   = rd_en_cnt;
    req_valid = 1'b1;
    req_addr  = a;
    if (stall > 0) flash_rready = 1'b0;
    @(negedge clk);
    check("ready_idle", 32'(req_ready), 1);
    exp_rsp.push_back(fw(a));
    if (!hit) exp_fetch.push_back(line);
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (hit) begin
      if (inval_at < 0) begin
        inval = 1'b1;
        clear_model();
      end
      @(negedge clk);
      check("hit_latency", 32'(rsp_valid), 1);
      check("ready_lookup", 32'(req_ready), 0);
      @(posedge clk); #1;
      inval = 1'b0;
      check("hit_no_fetch", 32'(rd_en_cnt), 32'(n0));
    end else begin
      for (int c = 0; c < stall; c++) begin
        @(posedge clk); #1;
      end
      if (stall > 0) begin
        check("stall_no_read_en", 32'(rd_en_cnt), 32'(n0));
        flash_rready = 1'b1;
      end
      seen = 0;
      for (int c = 0; c < 20 && !seen; c++) begin
        @(negedge clk);
        seen = flash_read_en;
      end
      if (!seen) begin
        check("read_en_timeout", 32'(flash_read_en), 1);
        abort_run();
      end
      check("ready_issue", 32'(req_ready), 0);
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        flash_dval = 1'b1;
        flash_dout = fw(line + 24'(4 * i));
        @(posedge clk); #1;
        flash_dval = 1'b0;
        if (i + 1 == rst_at) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          clear_model();
          exp_rsp.delete();
          exp_fetch.delete();
          last_rsp = '0;
          @(negedge clk);
          check("rst_ready", 32'(req_ready), 1);
          check("rst_no_rsp", 32'(rsp_valid), 0);
          for (int s = 0; s < 3; s++) begin
            @(posedge clk); #1;
            flash_dval = 1'b1;
            flash_dout = 32'hDEAD_0000 + 32'(s);
          end
          @(posedge clk); #1;
          flash_dval = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          return;
        end
        if (i + 1 == inval_at) begin
          inval = 1'b1;
          clear_model();
          pend = 1;
          @(posedge clk); #1;
          inval = 1'b0;
        end
        check("flash_addr_stable", 32'(flash_addr), 32'(line));
      end
      @(negedge clk);
      check("miss_rsp_latency", 32'(rsp_valid), 1);
      check("single_read_en", 32'(rd_en_cnt), 32'(n0 + 1));
      if (!pend) begin
        m_valid[idx] = 1;
        m_tag[idx]   = tg;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 1);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_read_en", 32'(flash_read_en), 0);
    check("reset_flash_addr", 32'(flash_addr), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1;

    // cold miss then hit in the same line
    do_req(24'h000104, 0, 0, 0);
    check("lit_cold_A1", last_rsp, 32'hD000_0104);
    check("lit_cold_fetch", 32'(last_faddr), 32'h0000_0100);
    n = rd_en_cnt;
    do_req(24'h00010C, 0, 0, 0);
    check("lit_hit_A3", last_rsp, 32'hD000_010C);
    check("lit_hit_nofetch", 32'(rd_en_cnt), 32'(n));

    // conflict on index 0
    do_req(24'h001100, 0, 0, 0);
    check("lit_conflict_fetch", 32'(last_faddr), 32'h0000_1100);
    check("lit_conflict_data", last_rsp, 32'hD000_1100);
    n = rd_en_cnt;
    do_req(24'h000100, 0, 0, 0);
    check("lit_conflict_refetch", 32'(rd_en_cnt), 32'(n + 1));

    // flash not ready for 10 cycles, then a hit with low address bits set
    do_req(24'h000208, 10, 0, 0);
    do_req(24'h00020F, 0, 0, 0);
    check("lit_lowbits", last_rsp, 32'hD000_020C);

    // inval mid-fill: response still returned, line stays invalid
    do_req(24'h0003F4, 0, 2, 0);
    check("lit_inval_rsp", last_rsp, 32'hD000_03F4);
    n = rd_en_cnt;
    do_req(24'h0003F4, 0, 0, 0);
    check("lit_inval_refetch", 32'(rd_en_cnt), 32'(n + 1));

    // inval together with a hit still returns the hit word
    do_req(24'h0003F8, 0, -1, 0);
    check("lit_inval_hit", last_rsp, 32'hD000_03F8);
    do_req(24'h0003F0, 0, 0, 0);
    do_req(24'h000208, 0, 0, 0);

    // reset mid-fill
    do_req(24'h000500, 0, 0, 1);
    n = rd_en_cnt;
    do_req(24'h000504, 0, 0, 0);
    check("lit_rst_refetch", 32'(rd_en_cnt), 32'(n + 1));
    check("lit_rst_fetch", 32'(last_faddr), 32'h0000_0500);
    do_req(24'h000500, 0, 0, 0);

    repeat (3) @(posedge clk);
    check("queues_drained", 32'(exp_rsp.size() + exp_fetch.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/qspi_cache_ctrl.md
QSPI_CACHE_CTRL -- requirements
Module: qspi_cache_ctrl

Interface
REQ-001 SHALL have parameter LINES, default 16, number of direct-mapped cache lines (power of 2, 2..256).
REQ-002 SHALL have parameter LINE_WORDS, default 4, number of 32-bit words per line (power of 2, 1..16).
REQ-003 SHALL have port clk, input, 1, the clock.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1, CPU read request.
REQ-006 SHALL have port req_addr, input, 24, CPU byte address; bits [1:0] are ignored.
REQ-007 SHALL have port req_ready, output, 1, high only when a request can be accepted.
REQ-008 SHALL have port rsp_valid, output, 1, single-cycle response strobe.
REQ-009 SHALL have port rsp_data, output, 32, response word.
REQ-010 SHALL have port inval, input, 1, pulse that invalidates all lines.
REQ-011 SHALL have port flash_addr, output, 24, line-aligned flash read address.
REQ-012 SHALL have port flash_read_en, output, 1, single-cycle burst start.
REQ-013 SHALL have port flash_dout, input, 32, word from the QSPI interface.
REQ-014 SHALL have port flash_dval, input, 1, flash_dout valid strobe.
REQ-015 SHALL have port flash_rready, input, 1, QSPI interface idle and ready for a read.

Function
REQ-016 SHALL split the address as: word offset = [log2(LINE_WORDS)+1:2]; index = the next log2(LINES) bits; tag = the remaining upper bits.
REQ-017 SHALL implement FSM states IDLE, LOOKUP, ISSUE, FILL and RESPOND.
REQ-018 SHALL drive req_ready=1 only in IDLE; a handshake (req_valid & req_ready) latches req_addr and moves the FSM to LOOKUP.
REQ-019 In LOOKUP, on a hit (valid[index] and tag match), SHALL assert rsp_valid with the cached word for one cycle and return to IDLE; hit latency is 1 cycle after acceptance.
REQ-020 In LOOKUP, on a miss, SHALL go to ISSUE.
REQ-021 In ISSUE, SHALL hold flash_addr = {tag, index, zero offset}; when flash_rready=1, SHALL pulse flash_read_en for exactly one cycle and enter FILL.
REQ-022 SHALL keep flash_addr stable from ISSUE until FILL completes.
REQ-023 In FILL, each flash_dval SHALL write flash_dout into word fill_cnt of the line and increment fill_cnt, which starts at 0.
REQ-024 flash_dval outside FILL SHALL be ignored.
REQ-025 After LINE_WORDS words, SHALL write the tag, set valid[index] (unless REQ-028 applies) and enter RESPOND.
REQ-026 RESPOND SHALL assert rsp_valid with the requested word for one cycle, then return to IDLE.
REQ-027 The QSPI interface delivers exactly LINE_WORDS words, byte-order already corrected, per flash_read_en.
REQ-028 inval SHALL clear all valid bits on the next edge in any state; inval during LOOKUP, ISSUE or FILL SHALL set a pending flag that suppresses the valid set of REQ-025, while the response is still returned.
REQ-029 inval in the same cycle as a hit in LOOKUP SHALL still return the hit data.
REQ-030 rsp_valid SHALL have no backpressure; rsp_data SHALL hold its last value when rsp_valid=0.
REQ-031 The data array is not reset; only the valid bits are.

Reset
REQ-032 rst SHALL force: state IDLE, all valid bits 0, fill_cnt 0, pending-inval flag 0, rsp_valid 0, rsp_data 0, flash_read_en 0, flash_addr 0.
REQ-033 rst during FILL SHALL abandon the line; any further flash_dval SHALL be ignored.

Structure
REQ-034 A shared package qspi_cache_pkg SHALL hold the state enum cache_state_t, the address width ADDR_W=24, DATA_W=32, and address-field width functions.
REQ-035 Tag, valid and data storage SHALL be one sub-module, cache_mem (flop arrays, one write port, one asynchronous read port); the FSM and fill counter live in qspi_cache_ctrl.

Verification
REQ-036 Cold miss: after reset, request 0x000104:
- one flash_read_en with flash_addr=0x000100;
- feed 4 words A0..A3;
- rsp_data=A1 one cycle after the 4th dval.
REQ-037 Hit: then request 0x00010C: rsp_valid on the cycle after acceptance, rsp_data=A3, and no flash_read_en.
REQ-038 Conflict: request 0x001100 (same index, different tag):
- refill from 0x001100;
- a subsequent 0x000100 request misses again.
REQ-039 Flow control: hold flash_rready=0 for 10 cycles in ISSUE; flash_read_en is asserted only once, on the first cycle flash_rready=1.
REQ-040 Invalidate mid-fill: pulse inval after the 2nd dval:
- the response is still returned;
- the same address then misses and refetches.
REQ-041 Reset mid-fill: assert rst after the 1st dval:
- req_ready=1 and rsp_valid=0 after reset;
- stray dval pulses produce no response;
- the next request misses.
